// File: rtl/jtag_host_driver.sv
// jtag_host_driver: host-side JTAG sequencer. Turns TAP reset / IR shift /
// DR shift / idle-cycle commands into tck/tms/tdi/trst_n waveforms and
// captures tdo. Every command starts and ends in Run-Test/Idle.
// Optional: define JTAG_HOST_DRIVER_TCK_FREERUN_EN to keep tck toggling in
// IDLE; accepted commands then launch on the next tck falling edge.
module jtag_host_driver #(
    parameter int CLK_DIV  = 4,
    parameter int MAX_BITS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [5:0]          cmd_len,
    input  logic [MAX_BITS-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [MAX_BITS-1:0] rsp_data,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo,
    output logic                trst_n
);

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_RUN   = 2'd3;
    localparam logic [6:0] MAX_LEN  = 7'(MAX_BITS);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TRST, S_TLR, S_NAV, S_SHIFT, S_EXIT, S_DONE
    } state_t;

    state_t              state, next_state;
    logic [7:0]          div_cnt;
    logic [6:0]          step, len_reg, last_step, len_in, launch_len;
    logic [1:0]          op_reg, launch_op;
    logic [MAX_BITS-1:0] data_sr, cap_sr, launch_data;
    logic                alive, busy, div_run, at_last, rise_tick, fall_tick;
    logic                accept, launch;
`ifdef JTAG_HOST_DRIVER_TCK_FREERUN_EN
    logic                pending;
`endif

    // State register for the command sequencer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Tick decode, command launch selection and next-state logic.
    always_comb begin
        busy      = state inside {S_TRST, S_TLR, S_NAV, S_SHIFT, S_EXIT};
        at_last   = (div_cnt == DIV_LAST);
        len_in    = ({1'b0, cmd_len} > MAX_LEN) ? MAX_LEN : {1'b0, cmd_len};
        rsp_valid = (state == S_DONE);
`ifdef JTAG_HOST_DRIVER_TCK_FREERUN_EN
        div_run     = 1'b1;
        cmd_ready   = alive && (state == S_IDLE) && !pending;
        rise_tick   = div_run && !tck && at_last;
        fall_tick   = div_run && tck && at_last;
        accept      = cmd_valid && cmd_ready;
        launch      = (state == S_IDLE) && pending && fall_tick;
        launch_op   = op_reg;
        launch_len  = len_reg;
        launch_data = data_sr;
`else
        div_run     = busy;
        cmd_ready   = alive && (state == S_IDLE);
        rise_tick   = div_run && !tck && at_last;
        fall_tick   = div_run && tck && at_last;
        accept      = cmd_valid && cmd_ready;
        launch      = accept;
        launch_op   = cmd_op;
        launch_len  = len_in;
        launch_data = cmd_data;
`endif
        case (state)
            S_TLR:   last_step = 7'd5;
            S_NAV:   last_step = (op_reg == OP_IR) ? 7'd3 : 7'd2;
            S_SHIFT: last_step = len_reg - 7'd1;
            S_EXIT:  last_step = 7'd1;
            default: last_step = 7'd0;
        endcase
        next_state = state;
        case (state)
            S_IDLE: begin
                if (launch) begin
                    if (launch_op == OP_RESET)  next_state = S_TRST;
                    else if (launch_len == 0)   next_state = S_DONE;
                    else if (launch_op == OP_RUN) next_state = S_SHIFT;
                    else                        next_state = S_NAV;
                end
            end
            S_DONE: next_state = S_IDLE;
            default: begin
                if (fall_tick && step == last_step) begin
                    case (state)
                        S_TRST:  next_state = S_TLR;
                        S_NAV:   next_state = S_SHIFT;
                        S_SHIFT: next_state = (op_reg == OP_RUN) ? S_DONE : S_EXIT;
                        default: next_state = S_DONE;
                    endcase
                end
            end
        endcase
    end

    // TCK divider, pin drive, shift registers and response capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alive    <= 1'b0;
            div_cnt  <= '0;
            tck      <= 1'b0;
            tms      <= 1'b1;
            tdi      <= 1'b0;
            trst_n   <= 1'b0;
            step     <= '0;
            op_reg   <= '0;
            len_reg  <= '0;
            data_sr  <= '0;
            cap_sr   <= '0;
            rsp_data <= '0;
`ifdef JTAG_HOST_DRIVER_TCK_FREERUN_EN
            pending  <= 1'b0;
`endif
        end else begin
            alive <= 1'b1;
            if (!alive) trst_n <= 1'b1;
            if (div_run) begin
                if (at_last) begin
                    div_cnt <= '0;
                    tck     <= ~tck;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end else begin
                div_cnt <= '0;
                tck     <= 1'b0;
            end
`ifdef JTAG_HOST_DRIVER_TCK_FREERUN_EN
            if (accept) begin
                pending <= 1'b1;
                op_reg  <= cmd_op;
                len_reg <= len_in;
                data_sr <= cmd_data;
            end
            if (launch) pending <= 1'b0;
`endif
            if (launch) begin
                op_reg  <= launch_op;
                len_reg <= launch_len;
                data_sr <= launch_data;
                cap_sr  <= '0;
                step    <= '0;
                if (launch_op == OP_RESET) begin
                    trst_n <= 1'b0;
                    tms    <= 1'b1;
                    tdi    <= 1'b0;
                end else if (launch_len != 0) begin
                    tms <= (launch_op != OP_RUN);
                    tdi <= 1'b0;
                end else begin
                    rsp_data <= '0;
                end
            end
            if (rise_tick && state == S_SHIFT && op_reg != OP_RUN)
                cap_sr <= {tdo, cap_sr[MAX_BITS-1:1]};
            if (fall_tick && busy) begin
                if (step == last_step) begin
                    step <= '0;
                    case (state)
                        S_TRST:  begin tms <= 1'b1; trst_n <= 1'b1; end
                        S_NAV:   begin tms <= (len_reg == 7'd1); tdi <= data_sr[0]; end
                        S_SHIFT: begin tms <= (op_reg != OP_RUN); tdi <= 1'b0; end
                        default: tms <= 1'b0;
                    endcase
                    if (next_state == S_DONE)
                        rsp_data <= cap_sr >> (MAX_LEN - len_reg);
                end else begin
                    step <= step + 7'd1;
                    case (state)
                        S_TLR:   tms <= (step != 7'd4);
                        S_NAV:   tms <= (op_reg == OP_IR) && (step == 7'd0);
                        S_SHIFT: begin
                            if (op_reg == OP_RUN) begin
                                tms <= 1'b0;
                                tdi <= 1'b0;
                            end else begin
                                tms     <= (step + 7'd1 == len_reg - 7'd1);
                                tdi     <= data_sr[1];
                                data_sr <= data_sr >> 1;
                            end
                        end
                        default: tms <= 1'b0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_host_driver.sv
// Scoreboard bench for jtag_host_driver: the stimulus side builds each
// command's expected TCK count, tms/tdi/trst_n sequence, latency and
// response; a monitor records the pins at every tck rise and compares on
// rsp_valid.
module tb_jtag_host_driver;

    localparam int D  = 4;
    localparam int MB = 32;

    typedef struct {
        logic [31:0] rsp;
        int          ntck;
        int          lat;
        logic [63:0] tms;
        logic [63:0] tms_m;
        logic [63:0] tdi;
        logic [63:0] tdi_m;
        logic [63:0] trst;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = '0;
    logic [5:0]  cmd_len = '0;
    logic [31:0] cmd_data = '0;
    logic        cmd_ready, rsp_valid, tck, tms, tdi, tdo, trst_n;
    logic [31:0] rsp_data;
    logic [63:0] tdo_pat = '0;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          rise_cnt = 0;
    int          lat = 0;
    int          done_cnt = 0;
    int          post_cnt = 0;
    bit          in_cmd = 0;
    bit          prev_tck = 0;
    bit          rsp_prev = 0;
    logic [63:0] tms_log = '0;
    logic [63:0] tdi_log = '0;
    logic [63:0] trst_log = '0;

    jtag_host_driver #(.CLK_DIV(D), .MAX_BITS(MB)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .tck(tck), .tms(tms),
        .tdi(tdi), .tdo(tdo), .trst_n(trst_n)
    );

    always #5 clk = ~clk;

    // TAP stand-in: presents pattern bit k before the k-th tck rise.
    assign tdo = tdo_pat[rise_cnt[5:0]];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: reset values, pin log at tck rises, scoreboard compare on rsp_valid.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            checkOutput("reset_ctrl", {58'd0, cmd_ready, rsp_valid, tck, tms, tdi, trst_n}, 64'b000100);
            checkOutput("reset_rsp_data", {32'd0, rsp_data}, 64'd0);
            in_cmd = 0; prev_tck = 0; rsp_prev = 0; post_cnt = 0;
        end else begin
            post_cnt++;
            if (post_cnt == 2)
                checkOutput("post_reset", {61'd0, cmd_ready, tck, trst_n}, 64'b101);
            if (rsp_prev)
                checkOutput("rsp_pulse_width", {63'd0, rsp_valid}, 64'd0);
            if (!in_cmd && cmd_ready && !cmd_valid)
                checkOutput("idle_tck", {63'd0, tck}, 64'd0);
            if (in_cmd) lat++;
            if (in_cmd && tck && !prev_tck) begin
                tms_log[rise_cnt[5:0]]  = tms;
                tdi_log[rise_cnt[5:0]]  = tdi;
                trst_log[rise_cnt[5:0]] = trst_n;
                rise_cnt++;
            end
            if (cmd_valid && cmd_ready) begin
                in_cmd = 1; lat = 0; rise_cnt = 0;
                tms_log = '0; tdi_log = '0; trst_log = '0;
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("rsp_data", {32'd0, rsp_data}, {32'd0, e.rsp});
                    checkOutput("tck_count", 64'(rise_cnt), 64'(e.ntck));
                    checkOutput("rsp_latency", 64'(lat), 64'(e.lat));
                    checkOutput("tms_seq", tms_log & e.tms_m, e.tms & e.tms_m);
                    checkOutput("tdi_seq", tdi_log & e.tdi_m, e.tdi & e.tdi_m);
                    checkOutput("trst_seq", trst_log & e.tms_m | trst_log & e.tdi_m | trst_log, e.trst);
                end
                in_cmd = 0;
                done_cnt++;
            end else if (in_cmd && lat > 2 * D * 40 + 20) begin
                checkOutput("rsp_timeout", {63'd0, rsp_valid}, 64'd1);
                if (sb.size() != 0) e = sb.pop_front();
                in_cmd = 0;
                done_cnt++;
            end
            prev_tck = tck;
            rsp_prev = rsp_valid;
        end
    end

    // Builds the expected result from the command rules and issues the command.
    task automatic applyStimulus(input logic [1:0] op, input int len, input logic [31:0] data,
                                 input logic [63:0] pat, input bit expect_rsp);
        exp_t e;
        int n, off;
        logic [63:0] m;
        n = (len > MB) ? MB : len;
        e.rsp = '0; e.tms = '0; e.tms_m = '0; e.tdi = '0; e.tdi_m = '0; e.ntck = 0;
        if (op == 2'd0) begin
            e.ntck = 7;
            for (int i = 1; i <= 5; i++) e.tms[i] = 1'b1;
        end else if (n == 0) begin
            e.ntck = 0;
        end else if (op == 2'd3) begin
            e.ntck = n;
        end else begin
            off = (op == 2'd1) ? 4 : 3;
            e.tms[0] = 1'b1;
            if (op == 2'd1) e.tms[1] = 1'b1;
            for (int i = 0; i < n; i++) begin
                e.tms[off + i]   = (i == n - 1);
                e.tdi[off + i]   = data[i];
                e.tdi_m[off + i] = 1'b1;
                e.rsp[i]         = pat[off + i];
            end
            e.tms[off + n] = 1'b1;
            e.ntck = off + n + 2;
        end
        m = (e.ntck == 0) ? 64'd0 : ((64'd1 << e.ntck) - 64'd1);
        e.tms_m = (op == 2'd0) ? (m & ~64'd1) : m;
        if (op == 2'd3) e.tdi_m = m;
        e.trst = m;
        if (op == 2'd0) e.trst[0] = 1'b0;
        e.lat = 1 + 2 * D * e.ntck;
        if (expect_rsp) sb.push_back(e);
        tdo_pat   = pat;
        cmd_op    = op;
        cmd_len   = len[5:0];
        cmd_data  = data;
        cmd_valid = 1'b1;
        for (int i = 0; ; i++) begin
            @(negedge clk); #1;
            if (cmd_ready) break;
            if (i > 500) begin
                $display("[TB] FAIL cmd_ready_timeout actual=0 required=1");
                $fatal(1, "[TB] stuck waiting for cmd_ready");
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitDone(input int prev);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk); #1;
            if (done_cnt != prev) return;
        end
        $display("[TB] FAIL done_timeout actual=%0d required=%0d", done_cnt, prev + 1);
        $fatal(1, "[TB] stuck waiting for completion");
    endtask

    task automatic runCmd(input logic [1:0] op, input int len, input logic [31:0] data, input logic [63:0] pat);
        int prev;
        prev = done_cnt;
        applyStimulus(op, len, data, pat, 1'b1);
        waitDone(prev);
    endtask

    initial begin
        logic [63:0] pat;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        $display("[TB] TAP reset");
        runCmd(2'd0, 0, 32'd0, {$urandom, $urandom});
        $display("[TB] IDCODE readout");
        pat = '0;
        pat[34:3] = 32'h000FAF01;
        runCmd(2'd2, 32, 32'd0, pat);
        $display("[TB] IR shift loopback");
        pat = '0;
        pat[7:4] = 4'hF;
        runCmd(2'd1, 4, 32'h0000000F, pat);
        $display("[TB] clamp and zero length");
        runCmd(2'd2, 40, $urandom, {$urandom, $urandom});
        runCmd(2'd3, 0, $urandom, {$urandom, $urandom});
        runCmd(2'd1, 0, $urandom, {$urandom, $urandom});
        runCmd(2'd2, 0, $urandom, {$urandom, $urandom});
        runCmd(2'd3, 5, $urandom, {$urandom, $urandom});
        $display("[TB] random commands");
        for (int k = 0; k < 20; k++)
            runCmd(2'($urandom_range(0, 3)), $urandom_range(0, 40), $urandom, {$urandom, $urandom});
        $display("[TB] reset during DR shift");
        applyStimulus(2'd2, 32, $urandom, {$urandom, $urandom}, 1'b0);
        for (int i = 0; ; i++) begin
            @(negedge clk); #1;
            if (rise_cnt >= 14) break;
            if (i > 2000) begin
                $display("[TB] FAIL abort_wait actual=%0d required=14", rise_cnt);
                $fatal(1, "[TB] shift never reached bit 10");
            end
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        runCmd(2'd0, 0, 32'd0, {$urandom, $urandom});
        runCmd(2'd2, 12, $urandom, {$urandom, $urandom});
        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
